// File: rtl/idma_inst64_ctrl.sv
// Sequencing controller for the iDMA inst64 frontend: decodes DMA instructions, holds the
// transfer configuration, issues one backend job per copy and answers status queries.
// Optional multicast register: define IDMA_INST64_MCAST_EN.
// Encodings (opcode 0101011, funct3 000), by funct7: 0 DMSRC, 1 DMDST, 2 DMCPYI, 3 DMCPY,
// 4 DMSTATI, 5 DMSTAT, 6 DMSTR, 7 DMREP, 8 DMMCAST.
module idma_inst64_ctrl #(
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned MaxOutstanding = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 acc_qvalid_i,
  output logic                 acc_qready_o,
  input  logic [31:0]          acc_qinstr_i,
  input  logic [31:0]          acc_qdata_op_a_i,
  input  logic [31:0]          acc_qdata_op_b_i,
  input  logic [4:0]           acc_qid_i,
  output logic                 acc_pvalid_o,
  input  logic                 acc_pready_i,
  output logic [31:0]          acc_pdata_o,
  output logic [4:0]           acc_pid_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [AddrWidth-1:0] req_src_o,
  output logic [AddrWidth-1:0] req_dst_o,
  output logic [31:0]          req_len_o,
  output logic [31:0]          req_src_stride_o,
  output logic [31:0]          req_dst_stride_o,
  output logic [31:0]          req_reps_o,
  output logic                 req_2d_o,
  output logic                 req_decouple_o,
  output logic [31:0]          req_mcast_o,
  input  logic                 rsp_valid_i,
  input  logic                 busy_i
);

  localparam logic [31:0] MaxOut    = 32'(MaxOutstanding);
  localparam logic [6:0]  OpcodeDma = 7'b0101011;

  if (AddrWidth <= 32 || AddrWidth > 64) begin : g_bad_addr_width
    $error("AddrWidth must satisfy 32 < AddrWidth <= 64");
  end
  if (MaxOutstanding < 1 || MaxOutstanding > 65536) begin : g_bad_max_outstanding
    $error("MaxOutstanding must lie in 1..65536");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  typedef enum logic [2:0] {
    OP_NONE, OP_SRC, OP_DST, OP_CPY, OP_STAT, OP_STR, OP_REP, OP_MCAST
  } op_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] src_q, src_d;
  logic [AddrWidth-1:0] dst_q, dst_d;
  logic [31:0]          src_stride_q, src_stride_d;
  logic [31:0]          dst_stride_q, dst_stride_d;
  logic [31:0]          reps_q, reps_d;
  logic [31:0]          len_q, len_d;
  logic                 twod_q, twod_d;
  logic                 decouple_q, decouple_d;
  logic [31:0]          pdata_q, pdata_d;
  logic [4:0]           pid_q, pid_d;
  logic [31:0]          next_id_q, next_id_d;
  logic [31:0]          completed_id_q, completed_id_d;

  logic [6:0]  funct7, opcode;
  logic [4:0]  rs2_f, rs1_f, rd_f;
  logic [2:0]  funct3;
  op_e         op;
  logic        use_imm;
  logic [4:0]  imm5;
  logic [63:0] op_ab;
  logic        acc_hs;
  logic        full;
  logic [31:0] outstanding, outstanding_post;
  logic [31:0] stat_val;

  assign {funct7, rs2_f, rs1_f, funct3, rd_f, opcode} = acc_qinstr_i;
  assign op_ab = {acc_qdata_op_b_i, acc_qdata_op_a_i};

  always_comb begin
    op      = OP_NONE;
    use_imm = 1'b0;
    if (opcode == OpcodeDma && funct3 == 3'b000) begin
      case (funct7)
        7'd0: if (rd_f == 5'd0) op = OP_SRC;
        7'd1: if (rd_f == 5'd0) op = OP_DST;
        7'd2: begin
          op      = OP_CPY;
          use_imm = 1'b1;
        end
        7'd3: op = OP_CPY;
        7'd4: if (rs1_f == 5'd0) begin
          op      = OP_STAT;
          use_imm = 1'b1;
        end
        7'd5: if (rs1_f == 5'd0) op = OP_STAT;
        7'd6: if (rd_f == 5'd0) op = OP_STR;
        7'd7: if (rd_f == 5'd0 && rs2_f == 5'd0) op = OP_REP;
        7'd8: if (rd_f == 5'd0 && rs2_f == 5'd0) op = OP_MCAST;
        default: op = OP_NONE;
      endcase
    end
  end

  assign imm5 = use_imm ? rs2_f : acc_qdata_op_b_i[4:0];

  // Completions are counted only while something is outstanding; a stray pulse is dropped.
  assign outstanding = next_id_q - 32'd1 - completed_id_q;
  assign full        = (outstanding == MaxOut);

  always_comb begin
    completed_id_d = completed_id_q;
    if (rsp_valid_i && outstanding != 32'd0) completed_id_d = completed_id_q + 32'd1;
  end

  // Status answers include a completion arriving in the accepting cycle.
  assign outstanding_post = next_id_q - 32'd1 - completed_id_d;

  always_comb begin
    case (imm5)
      5'd0:    stat_val = completed_id_d;
      5'd1:    stat_val = next_id_q;
      5'd2:    stat_val = {31'd0, busy_i | (outstanding_post != 32'd0)};
      5'd3:    stat_val = {31'd0, outstanding_post == MaxOut};
      default: stat_val = 32'd0;
    endcase
  end

  assign acc_qready_o = (state_q == IDLE) && !(op == OP_CPY && full);
  assign acc_hs       = acc_qvalid_i && acc_qready_o;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    src_stride_d = src_stride_q;
    dst_stride_d = dst_stride_q;
    reps_d       = reps_q;
    len_d        = len_q;
    twod_d       = twod_q;
    decouple_d   = decouple_q;
    pdata_d      = pdata_q;
    pid_d        = pid_q;
    next_id_d    = next_id_q;
    if (acc_hs) begin
      case (op)
        OP_SRC: src_d = op_ab[AddrWidth-1:0];
        OP_DST: dst_d = op_ab[AddrWidth-1:0];
        OP_STR: begin
          src_stride_d = acc_qdata_op_a_i;
          dst_stride_d = acc_qdata_op_b_i;
        end
        OP_REP: reps_d = acc_qdata_op_a_i;
        OP_CPY: begin
          len_d      = acc_qdata_op_a_i;
          decouple_d = imm5[0];
          twod_d     = imm5[1];
          pid_d      = acc_qid_i;
          state_d    = ISSUE;
        end
        OP_STAT: begin
          pdata_d = stat_val;
          pid_d   = acc_qid_i;
          state_d = RESP;
        end
        default: ;
      endcase
    end
    case (state_q)
      ISSUE: if (req_ready_i) begin
        pdata_d   = next_id_q;
        next_id_d = next_id_q + 32'd1;
        state_d   = RESP;
      end
      RESP: if (acc_pready_i) state_d = IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      src_stride_q   <= '0;
      dst_stride_q   <= '0;
      reps_q         <= '0;
      len_q          <= '0;
      twod_q         <= 1'b0;
      decouple_q     <= 1'b0;
      pdata_q        <= '0;
      pid_q          <= '0;
      next_id_q      <= 32'd1;
      completed_id_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      src_stride_q   <= src_stride_d;
      dst_stride_q   <= dst_stride_d;
      reps_q         <= reps_d;
      len_q          <= len_d;
      twod_q         <= twod_d;
      decouple_q     <= decouple_d;
      pdata_q        <= pdata_d;
      pid_q          <= pid_d;
      next_id_q      <= next_id_d;
      completed_id_q <= completed_id_d;
    end
  end

`ifdef IDMA_INST64_MCAST_EN
  logic [31:0] mcast_q, mcast_d;

  always_comb begin
    mcast_d = mcast_q;
    if (acc_hs && op == OP_MCAST) mcast_d = acc_qdata_op_a_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mcast_q <= '0;
    else       mcast_q <= mcast_d;
  end

  assign req_mcast_o = mcast_q;
`else
  assign req_mcast_o = 32'd0;
`endif

  assign req_valid_o      = (state_q == ISSUE);
  assign req_src_o        = src_q;
  assign req_dst_o        = dst_q;
  assign req_len_o        = len_q;
  assign req_src_stride_o = src_stride_q;
  assign req_dst_stride_o = dst_stride_q;
  assign req_reps_o       = reps_q;
  assign req_2d_o         = twod_q;
  assign req_decouple_o   = decouple_q;
  assign acc_pvalid_o     = (state_q == RESP);
  assign acc_pdata_o      = pdata_q;
  assign acc_pid_o        = pid_q;

  // Upper operand bits beyond the address width and cfg[4:2] carry no meaning.
  logic unused_ok;
  assign unused_ok = ^{op_ab, imm5};

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (rst_i) rsp_valid_i |-> (outstanding != 32'd0));
`endif

endmodule

// File: tb/tb_idma_inst64_ctrl.sv
// Scoreboard bench for idma_inst64_ctrl: a transaction-level model predicts every backend job
// and every accelerator response; two monitors compare them as the DUT presents them.
`timescale 1ns/1ps
module tb_idma_inst64_ctrl;
  localparam int          AW     = 48;
  localparam int          MAXO   = 4;
  localparam logic [31:0] MAXO32 = 32'd4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          acc_qvalid_i = 1'b0;
  logic          acc_qready_o;
  logic [31:0]   acc_qinstr_i = '0;
  logic [31:0]   acc_qdata_op_a_i = '0;
  logic [31:0]   acc_qdata_op_b_i = '0;
  logic [4:0]    acc_qid_i = '0;
  logic          acc_pvalid_o;
  logic          acc_pready_i;
  logic [31:0]   acc_pdata_o;
  logic [4:0]    acc_pid_o;
  logic          req_valid_o;
  logic          req_ready_i;
  logic [AW-1:0] req_src_o, req_dst_o;
  logic [31:0]   req_len_o, req_src_stride_o, req_dst_stride_o, req_reps_o, req_mcast_o;
  logic          req_2d_o, req_decouple_o;
  logic          rsp_valid_i = 1'b0;
  logic          busy_i = 1'b0;

  always #5 clk = ~clk;

  idma_inst64_ctrl #(.AddrWidth(AW), .MaxOutstanding(MAXO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .acc_qvalid_i(acc_qvalid_i), .acc_qready_o(acc_qready_o), .acc_qinstr_i(acc_qinstr_i),
    .acc_qdata_op_a_i(acc_qdata_op_a_i), .acc_qdata_op_b_i(acc_qdata_op_b_i), .acc_qid_i(acc_qid_i),
    .acc_pvalid_o(acc_pvalid_o), .acc_pready_i(acc_pready_i), .acc_pdata_o(acc_pdata_o),
    .acc_pid_o(acc_pid_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_src_o(req_src_o), .req_dst_o(req_dst_o), .req_len_o(req_len_o),
    .req_src_stride_o(req_src_stride_o), .req_dst_stride_o(req_dst_stride_o),
    .req_reps_o(req_reps_o), .req_2d_o(req_2d_o), .req_decouple_o(req_decouple_o),
    .req_mcast_o(req_mcast_o), .rsp_valid_i(rsp_valid_i), .busy_i(busy_i)
  );

  typedef struct packed {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [31:0]   len;
    logic [31:0]   sstr;
    logic [31:0]   dstr;
    logic [31:0]   reps;
    logic [31:0]   mcast;
    logic          twod;
    logic          dec;
  } req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  id;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   hold_low = 1'b0;

  // Architectural state as seen by software.
  logic [AW-1:0] m_src, m_dst;
  logic [31:0]   m_sstr, m_dstr, m_reps, m_mcast, m_next, m_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0101011};
  endfunction

  function automatic logic [31:0] stat_exp(input logic [4:0] sel, input logic busy);
    logic [31:0] out;
    out = m_next - 32'd1 - m_done;
    case (sel)
      5'd0:    return m_done;
      5'd1:    return m_next;
      5'd2:    return {31'd0, busy || (out != 32'd0)};
      5'd3:    return {31'd0, out == MAXO32};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_src = '0; m_dst = '0; m_sstr = '0; m_dstr = '0; m_reps = '0; m_mcast = '0;
    m_next = 32'd1; m_done = 32'd0;
    req_q.delete();
    rsp_q.delete();
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the instruction.
  task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    int n;
    acc_qinstr_i = ins; acc_qdata_op_a_i = a; acc_qdata_op_b_i = b; acc_qid_i = tag;
    acc_qvalid_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!acc_qready_o && n < 1000);
    if (!acc_qready_o) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got qready 0 after %0d cycles, want 1", n);
    end
    @(posedge clk); #1;
    acc_qvalid_i = 1'b0;
    acc_qinstr_i = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(acc_qready_o === 1'b1 && !acc_pvalid_o && !req_valid_o) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy controller after %0d cycles, want idle", n);
    end
    if (n > 0) begin
      @(posedge clk); #1;
    end
  endtask

  // kind: 0 DMSRC, 1 DMDST, 2 DMSTR, 3 DMREP, 4 DMMCAST
  task automatic do_cfg(input int kind, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ab;
    logic [4:0]  r1, r2;
    ab = {b, a};
    r1 = 5'($urandom_range(1, 31));
    r2 = 5'($urandom_range(1, 31));
    case (kind)
      0: begin send(mk(7'd0, r2, r1, 5'd0), a, b, 5'd0); m_src = ab[AW-1:0]; end
      1: begin send(mk(7'd1, r2, r1, 5'd0), a, b, 5'd0); m_dst = ab[AW-1:0]; end
      2: begin send(mk(7'd6, r2, r1, 5'd0), a, b, 5'd0); m_sstr = a; m_dstr = b; end
      3: begin send(mk(7'd7, 5'd0, r1, 5'd0), a, b, 5'd0); m_reps = a; end
      default: begin
        send(mk(7'd8, 5'd0, r1, 5'd0), a, b, 5'd0);
`ifdef IDMA_INST64_MCAST_EN
        m_mcast = a;
`endif
      end
    endcase
  endtask

  task automatic do_cpy(input bit imm, input logic [4:0] cfg, input logic [31:0] len,
                        input logic [4:0] tag);
    logic [31:0] b;
    req_t        e;
    rsp_t        r;
    b = $urandom();
    if (!imm) b[4:0] = cfg;
    send(mk(imm ? 7'd2 : 7'd3, imm ? cfg : 5'($urandom_range(1, 31)),
            5'($urandom_range(1, 31)), tag), len, b, tag);
    e = {m_src, m_dst, len, m_sstr, m_dstr, m_reps, m_mcast, cfg[1], cfg[0]};
    req_q.push_back(e);
    r = {m_next, tag};
    rsp_q.push_back(r);
    m_next = m_next + 32'd1;
  endtask

  task automatic do_stat(input bit imm, input logic [4:0] sel, input logic [4:0] tag,
                         input logic busy);
    logic [31:0] b;
    rsp_t        r;
    b = $urandom();
    if (!imm) b[4:0] = sel;
    busy_i = busy;
    send(mk(imm ? 7'd4 : 7'd5, imm ? sel : 5'($urandom_range(0, 31)), 5'd0, tag),
         $urandom(), b, tag);
    busy_i = 1'b0;
    r = {stat_exp(sel, busy), tag};
    rsp_q.push_back(r);
  endtask

  task automatic do_undecoded();
    logic [31:0] ins;
    ins = $urandom();
    ins[31:25] = 7'h7F;
    send(ins, $urandom(), $urandom(), 5'($urandom_range(0, 31)));
  endtask

  task automatic pulse_done();
    wait_idle();
    rsp_valid_i = 1'b1;
    @(posedge clk); #1;
    rsp_valid_i = 1'b0;
    m_done = m_done + 32'd1;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_i = 1'b1;
    #1;
    chk("reset_drops_req_valid", 64'(req_valid_o), 64'd0);
    chk("reset_drops_pvalid", 64'(acc_pvalid_o), 64'd0);
    model_reset();
    hold_low = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  // Backend and core handshake partners.
  initial begin
    req_ready_i = 1'b0;
    acc_pready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      req_ready_i  = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      acc_pready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : req_mon
    req_t cur, prev, e;
    bit   stalled;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        stalled = 1'b0;
      end else if (req_valid_o) begin
        cur = {req_src_o, req_dst_o, req_len_o, req_src_stride_o, req_dst_stride_o,
               req_reps_o, req_mcast_o, req_2d_o, req_decouple_o};
        chk("qready_while_issuing", 64'(acc_qready_o), 64'd0);
        if (stalled) begin
          checks++;
          if (cur !== prev) begin
            errors++;
            $display("FAIL req_stable: got %h, want %h", cur, prev);
          end
        end
        if (req_ready_i) begin
          stalled = 1'b0;
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected: got job src 0x%0h, want no job", req_src_o);
          end else begin
            e = req_q.pop_front();
            chk("req_src", 64'(cur.src), 64'(e.src));
            chk("req_dst", 64'(cur.dst), 64'(e.dst));
            chk("req_len", 64'(cur.len), 64'(e.len));
            chk("req_src_stride", 64'(cur.sstr), 64'(e.sstr));
            chk("req_dst_stride", 64'(cur.dstr), 64'(e.dstr));
            chk("req_reps", 64'(cur.reps), 64'(e.reps));
            chk("req_mcast", 64'(cur.mcast), 64'(e.mcast));
            chk("req_2d", 64'(cur.twod), 64'(e.twod));
            chk("req_decouple", 64'(cur.dec), 64'(e.dec));
            $display("job  src=0x%0h dst=0x%0h len=%0d 2d=%0d dec=%0d mcast=0x%0h",
                     cur.src, cur.dst, cur.len, cur.twod, cur.dec, cur.mcast);
          end
        end else begin
          stalled = 1'b1;
          prev = cur;
        end
      end
    end
  end

  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && acc_pvalid_o && acc_pready_i) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got data 0x%0h id %0d, want no response",
                   acc_pdata_o, acc_pid_o);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_data", 64'(acc_pdata_o), 64'(e.data));
          chk("rsp_id", 64'(acc_pid_o), 64'(e.id));
          $display("resp id=%0d data=0x%08h", acc_pid_o, acc_pdata_o);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no completion by %0t, want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [31:0] out;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_qready", 64'(acc_qready_o), 64'd1);
    chk("reset_pvalid", 64'(acc_pvalid_o), 64'd0);
    chk("reset_pdata", 64'(acc_pdata_o), 64'd0);
    chk("reset_pid", 64'(acc_pid_o), 64'd0);
    chk("reset_req_valid", 64'(req_valid_o), 64'd0);
    chk("reset_req_fields", 64'(|{req_src_o, req_dst_o, req_len_o, req_src_stride_o,
        req_dst_stride_o, req_reps_o, req_mcast_o, req_2d_o, req_decouple_o}), 64'd0);
    rst_i = 1'b0;

    // Basic copy with 48-bit source address.
    do_cfg(0, 32'h1000_0000, 32'h0000_0012);
    do_cfg(1, 32'h2000_0000, 32'h0);
    do_cpy(1'b1, 5'd0, 32'd64, 5'd7);
    wait_idle();

    // 2D decoupled copy held by the backend for five cycles.
    do_cfg(2, 32'd8, 32'd16);
    do_cfg(3, 32'd4, 32'd0);
    hold_low = 1'b1;
    do_cpy(1'b0, 5'd3, 32'd256, 5'd9);
    repeat (5) begin
      @(negedge clk);
      chk("held_req_valid", 64'(req_valid_o), 64'd1);
      chk("held_qready", 64'(acc_qready_o), 64'd0);
    end
    hold_low = 1'b0;
    @(posedge clk); #1;
    wait_idle();

    // Completion accounting and status selectors.
    do_reset();
    repeat (3) do_cpy(1'b1, 5'd0, 32'd32, 5'd1);
    pulse_done();
    pulse_done();
    do_stat(1'b1, 5'd0, 5'd2, 1'b0);
    do_stat(1'b1, 5'd1, 5'd3, 1'b0);
    do_stat(1'b1, 5'd2, 5'd4, 1'b0);
    pulse_done();
    do_stat(1'b1, 5'd2, 5'd5, 1'b0);
    do_stat(1'b0, 5'd2, 5'd6, 1'b1);
    do_stat(1'b0, 5'd9, 5'd7, 1'b1);
    wait_idle();

    // Full stall released by a completion one cycle later.
    do_reset();
    repeat (MAXO) do_cpy(1'b1, 5'd2, 32'd16, 5'd11);
    do_stat(1'b1, 5'd3, 5'd12, 1'b0);
    wait_idle();
    acc_qinstr_i = mk(7'd2, 5'd1, 5'd3, 5'd13);
    acc_qdata_op_a_i = 32'd128; acc_qdata_op_b_i = 32'd0; acc_qid_i = 5'd13;
    acc_qvalid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_stall_qready", 64'(acc_qready_o), 64'd0);
    end
    @(posedge clk); #1;
    rsp_valid_i = 1'b1;
    @(negedge clk);
    chk("full_same_cycle_qready", 64'(acc_qready_o), 64'd0);
    @(posedge clk); #1;
    rsp_valid_i = 1'b0;
    m_done = m_done + 32'd1;
    @(negedge clk);
    chk("full_release_qready", 64'(acc_qready_o), 64'd1);
    @(posedge clk); #1;
    acc_qvalid_i = 1'b0; acc_qinstr_i = '0;
    req_q.push_back({m_src, m_dst, 32'd128, m_sstr, m_dstr, m_reps, m_mcast, 1'b0, 1'b1});
    rsp_q.push_back({m_next, 5'd13});
    m_next = m_next + 32'd1;
    do_stat(1'b1, 5'd3, 5'd14, 1'b0);
    wait_idle();

    // Counter wrap-around.
    do_reset();
    force dut.next_id_q = 32'hFFFF_FFFF;
    force dut.completed_id_q = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.next_id_q;
    release dut.completed_id_q;
    m_next = 32'hFFFF_FFFF;
    m_done = 32'hFFFF_FFFE;
    do_cpy(1'b1, 5'd0, 32'd8, 5'd20);
    do_cpy(1'b1, 5'd0, 32'd8, 5'd21);
    do_stat(1'b1, 5'd3, 5'd22, 1'b0);
    do_stat(1'b1, 5'd2, 5'd23, 1'b0);
    do_stat(1'b1, 5'd1, 5'd24, 1'b0);
    pulse_done();
    pulse_done();
    do_stat(1'b1, 5'd2, 5'd25, 1'b0);
    do_stat(1'b1, 5'd0, 5'd26, 1'b0);
    repeat (MAXO) do_cpy(1'b1, 5'd0, 32'd8, 5'd27);
    do_stat(1'b1, 5'd3, 5'd28, 1'b0);
    wait_idle();

    // Multicast mask, then reset in the middle of an issue.
    do_reset();
    do_cfg(4, 32'h0000_00F0, 32'd0);
    do_cpy(1'b1, 5'd0, 32'd4, 5'd30);
    wait_idle();
    hold_low = 1'b1;
    do_cpy(1'b1, 5'd0, 32'd4, 5'd31);
    @(negedge clk);
    chk("pre_reset_req_valid", 64'(req_valid_o), 64'd1);
    do_reset();
    do_stat(1'b1, 5'd1, 5'd1, 1'b0);
    do_stat(1'b0, 5'd0, 5'd2, 1'b0);
    wait_idle();

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      out = m_next - 32'd1 - m_done;
      case (k)
        0, 1, 2: do_cfg($urandom_range(0, 4), $urandom(), $urandom());
        3, 4: begin
          if (out < MAXO32) do_cpy(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                                   $urandom(), 5'($urandom_range(0, 31)));
          else pulse_done();
        end
        5, 9: do_stat(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        6, 7: if (out != 32'd0) pulse_done();
        default: do_undecoded();
      endcase
    end

    wait_idle();
    repeat (3) @(posedge clk);
    chk("req_queue_drained", 64'(req_q.size()), 64'd0);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
